axis_compress: RTL and testbench

AXIS_COMPRESS -- requirements
Module: axis_compress

---
 rtl/axis_compress.sv | 181 ++++++++++++++++++
 tb/tb_axis_compress.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_compress.sv
// -----------------------------------------------------------------------------
// axis_compress
//   Merges runs of consecutive addresses on an AXI-Stream input into
//   {start, len} run records on an AXI-Stream output.  A record covers len+1
//   addresses, so this block is the exact inverse of axis_uncompress.
//
// Ports
//   clock      rising-edge clock
//   rst_n      asynchronous, active-low reset
//   clken      clock enable; no state change and no transfer while 0
//   s_tdata    input address (ASIZE bits)
//   s_tvalid   input beat valid
//   s_tlast    last address of a packet
//   s_tready   input beat accepted when high (with s_tvalid and clken)
//   m_tdata    output record {start[ASIZE-1:0], len[LSIZE-1:0]}
//   m_tvalid   output record valid
//   m_tready   downstream ready
//   m_tlast    record closes a packet
//   m_tkeep    constant all-ones
//   m_tuser    constant 0
//   dbg_state  current FSM state (0 IDLE, 1 ACC, 2 FLUSH)
//
// Handshake: a beat moves on either port only in a cycle where
// valid && ready && clken are all 1 at the rising edge.  A valid source
// holds its payload stable until that happens.
// -----------------------------------------------------------------------------
module axis_compress #(
    parameter  int ASIZE = 8,
    parameter  int LSIZE = 8,
    localparam int DW    = ASIZE + LSIZE,
    localparam int KW    = (DW + 7) / 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clken,
    input  logic [ASIZE-1:0] s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [KW-1:0]    m_tkeep,
    output logic             m_tuser,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // no open run
        S_ACC   = 2'd1,  // run open, accumulating
        S_FLUSH = 2'd2   // run closed by tlast, waiting for the output slot
    } state_t;

    state_t           state, state_d;
    logic [ASIZE-1:0] run_start, run_start_d;
    logic [LSIZE-1:0] run_len, run_len_d;
    logic             run_last, run_last_d;

    logic             load;
    logic [DW-1:0]    load_data;
    logic             load_last;

    logic             slot_free;
    logic             s_accept;
    logic             m_xfer;
    logic             consec;
    logic             len_max;
    logic [ASIZE-1:0] len_a;
    logic [ASIZE-1:0] next_addr;

    // Run length brought to address width; the consecutive test is mod 2^ASIZE
    // so truncating a wider length keeps the arithmetic exact.
    generate
        if (LSIZE >= ASIZE) begin : g_len_trunc
            assign len_a = run_len[ASIZE-1:0];
        end else begin : g_len_ext
            assign len_a = {{(ASIZE - LSIZE){1'b0}}, run_len};
        end
    endgenerate

    assign next_addr = run_start + len_a + ASIZE'(1);
    assign consec    = (s_tdata == next_addr);
    assign len_max   = &run_len;

    assign slot_free = !m_tvalid || m_tready;
    assign s_tready  = (state != S_FLUSH) && slot_free;
    assign s_accept  = s_tvalid && s_tready && clken;
    assign m_xfer    = m_tvalid && m_tready && clken;

    assign m_tkeep   = '1;
    assign m_tuser   = 1'b0;
    assign dbg_state = state;

    // Next-state / run update / output-load decision.
    always_comb begin
        state_d     = state;
        run_start_d = run_start;
        run_len_d   = run_len;
        run_last_d  = run_last;
        load        = 1'b0;
        load_data   = {run_start, run_len};
        load_last   = 1'b0;

        case (state)
            S_IDLE: begin
                if (s_accept) begin
                    run_start_d = s_tdata;
                    run_len_d   = '0;
                    run_last_d  = s_tlast;
                    state_d     = s_tlast ? S_FLUSH : S_ACC;
                end
            end

            S_ACC: begin
                if (s_accept) begin
                    if (consec && !len_max) begin
                        run_len_d = run_len + LSIZE'(1);
                    end else begin
                        // Break: the open run goes out now; acceptance already
                        // guarantees the output slot is free this edge.
                        load        = 1'b1;
                        load_data   = {run_start, run_len};
                        load_last   = 1'b0;
                        run_start_d = s_tdata;
                        run_len_d   = '0;
                    end
                    if (s_tlast) begin
                        run_last_d = 1'b1;
                        state_d    = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (clken && slot_free) begin
                    load       = 1'b1;
                    load_data  = {run_start, run_len};
                    load_last  = 1'b1;
                    run_last_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            run_start <= '0;
            run_len   <= '0;
            run_last  <= 1'b0;
        end else begin
            state     <= state_d;
            run_start <= run_start_d;
            run_len   <= run_len_d;
            run_last  <= run_last_d;
        end
    end

    // One-entry output register: a new load wins over the clearing transfer
    // so a record handed over in the same edge keeps m_tvalid high.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tlast  <= load_last;
            m_tdata  <= load_data;
        end else if (m_xfer) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_compress.sv
// -----------------------------------------------------------------------------
// tb_axis_compress
//   Self-checking bench for axis_compress (ASIZE=8, LSIZE=8).  Directed runs
//   use literal expected records; randomized packets use a reference model
//   that groups each packet into maximal runs of at most 2^LSIZE addresses.
//   A negedge monitor pops the expected queue on every output transfer and
//   checks the output register holds steady under backpressure.
// -----------------------------------------------------------------------------
module tb_axis_compress;

    localparam int ASIZE = 8;
    localparam int LSIZE = 8;
    localparam int DW    = ASIZE + LSIZE;
    localparam int KW    = (DW + 7) / 8;
    localparam int W     = DW + 1;   // {tlast, tdata}

    // ---------------- clock / reset ----------------
    logic             clock;
    logic             rst_n;
    logic             clken;
    logic [ASIZE-1:0] s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [KW-1:0]    m_tkeep;
    logic             m_tuser;
    logic [1:0]       dbg_state;

    axis_compress #(.ASIZE(ASIZE), .LSIZE(LSIZE)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .clken     (clken),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .m_tkeep   (m_tkeep),
        .m_tuser   (m_tuser),
        .dbg_state (dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]     exp_q[$];
    logic [ASIZE-1:0] pkt[$];
    int               n_cmp = 0;
    int               n_err = 0;

    // 0: constant 1, 1: random, 2: forced 0 (ready) / toggle (clken)
    int clken_mode = 0;
    int ready_mode = 0;

    initial begin
        clken = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (clken_mode)
                1:       clken = 1'($urandom_range(0, 1));
                2:       clken = ~clken;
                default: clken = 1'b1;
            endcase
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                1:       m_tready = 1'($urandom_range(0, 1));
                2:       m_tready = 1'b0;
                default: m_tready = 1'b1;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    initial begin : monitor
        logic         prev_hold;
        logic [W-1:0] prev_rec;
        logic [W-1:0] cur;
        logic [W-1:0] e;
        prev_hold = 1'b0;
        prev_rec  = '0;
        forever begin
            @(negedge clock);
            if (rst_n !== 1'b1) begin
                prev_hold = 1'b0;
            end else begin
                cur = {m_tlast, m_tdata};
                if (prev_hold) begin
                    n_cmp++;
                    if (m_tvalid !== 1'b1 || cur !== prev_rec) begin
                        n_err++;
                        $display("FAIL hold_stable: got valid=%b rec=%h expected valid=1 rec=%h",
                                 m_tvalid, cur, prev_rec);
                    end
                end
                if (m_tvalid === 1'b1 && m_tready === 1'b1 && clken === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_record: got %h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            n_err++;
                            $display("FAIL record: got {last,data}=%h expected %h", cur, e);
                        end
                    end
                end
                prev_hold = (m_tvalid === 1'b1) && !(m_tready === 1'b1 && clken === 1'b1);
                prev_rec  = cur;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Drives every address in pkt, holding each beat until it is accepted.
    task automatic send_pkt(input bit with_last);
        bit accepted;
        int guard;
        for (int i = 0; i < pkt.size(); i++) begin
            s_tvalid = 1'b1;
            s_tdata  = pkt[i];
            s_tlast  = with_last && (i == pkt.size() - 1);
            accepted = 1'b0;
            guard    = 0;
            while (!accepted) begin
                @(negedge clock);
                accepted = (s_tready === 1'b1) && (clken === 1'b1);
                step();
                guard++;
                if (!accepted && guard > 2000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL accept_timeout: beat %0d not accepted, expected acceptance", i);
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || m_tvalid === 1'b1) && g < 5000) begin
            step();
            g++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got %0d records outstanding valid=%b expected 0 outstanding valid=0",
                     exp_q.size(), m_tvalid);
        end
    endtask

    // Reference model: split the packet into maximal runs where each next
    // address is previous+1 (mod 2^ASIZE) and a run never exceeds 2^LSIZE
    // addresses; the final run carries tlast.
    task automatic model_pkt();
        int start;
        int cnt;
        start = int'(pkt[0]);
        cnt   = 1;
        for (int i = 1; i < pkt.size(); i++) begin
            if (int'(pkt[i]) == (start + cnt) % (1 << ASIZE) && cnt < (1 << LSIZE)) begin
                cnt++;
            end else begin
                exp_q.push_back({1'b0, ASIZE'(start), LSIZE'(cnt - 1)});
                start = int'(pkt[i]);
                cnt   = 1;
            end
        end
        exp_q.push_back({1'b1, ASIZE'(start), LSIZE'(cnt - 1)});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) step();
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got valid=%b last=%b expected 0 0", m_tvalid, m_tlast);
        end
        n_cmp++;
        if (m_tdata !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0", m_tdata);
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        n_cmp++;
        if (m_tkeep !== {KW{1'b1}} || m_tuser !== 1'b0) begin
            n_err++;
            $display("FAIL keep_user: got keep=%b user=%b expected all-ones 0", m_tkeep, m_tuser);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got ready=%b valid=%b expected 1 0", s_tready, m_tvalid);
        end
    endtask

    task automatic test_runs();
        // plain run
        pkt = '{8'd10, 8'd11, 8'd12, 8'd13};
        exp_q.push_back(17'h1_0A03);
        send_pkt(1);
        wait_drain();
        // broken run
        pkt = '{8'd5, 8'd6, 8'd9};
        exp_q.push_back(17'h0_0501);
        exp_q.push_back(17'h1_0900);
        send_pkt(1);
        wait_drain();
        // wrap merge
        pkt = '{8'd254, 8'd255, 8'd0};
        exp_q.push_back(17'h1_FE02);
        send_pkt(1);
        wait_drain();
        // saturation split
        pkt.delete();
        for (int i = 0; i < 256; i++) pkt.push_back(ASIZE'(i));
        pkt.push_back(8'd0);
        exp_q.push_back(17'h0_00FF);
        exp_q.push_back(17'h1_0000);
        send_pkt(1);
        wait_drain();
    endtask

    task automatic test_latency();
        clken_mode = 0;
        ready_mode = 0;
        step();
        step();
        // tlast-closed single beat: visible one cycle after acceptance
        exp_q.push_back(17'h1_4200);
        s_tvalid = 1'b1;
        s_tdata  = 8'h42;
        s_tlast  = 1'b1;
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        n_cmp++;
        if (m_tvalid !== 1'b0 || dbg_state !== 2'd2) begin
            n_err++;
            $display("FAIL latency_flush: got valid=%b state=%0d expected 0 2", m_tvalid, dbg_state);
        end
        step();
        n_cmp++;
        if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== 17'h1_4200) begin
            n_err++;
            $display("FAIL latency_last: got valid=%b rec=%h expected 1 14200", m_tvalid, {m_tlast, m_tdata});
        end
        // broken run appears on the edge that accepts the breaking beat
        exp_q.push_back(17'h0_0500);
        s_tvalid = 1'b1;
        s_tdata  = 8'd5;
        s_tlast  = 1'b0;
        step();
        s_tdata  = 8'd9;
        step();
        s_tvalid = 1'b0;
        n_cmp++;
        if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== 17'h0_0500) begin
            n_err++;
            $display("FAIL latency_break: got valid=%b rec=%h expected 1 00500", m_tvalid, {m_tlast, m_tdata});
        end
        pkt = '{8'd10};
        exp_q.push_back(17'h1_0901);
        send_pkt(1);
        wait_drain();
    endtask

    task automatic test_backpressure();
        ready_mode = 2;
        step();
        step();
        pkt = '{8'd1, 8'd3, 8'd5};
        exp_q.push_back(17'h0_0100);
        exp_q.push_back(17'h0_0300);
        exp_q.push_back(17'h1_0500);
        fork
            send_pkt(1);
            begin
                repeat (6) step();
                n_cmp++;
                if (s_tready !== 1'b0 || m_tvalid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_ready: got ready=%b valid=%b expected 0 1", s_tready, m_tvalid);
                end
                n_cmp++;
                if ({m_tlast, m_tdata} !== 17'h0_0100) begin
                    n_err++;
                    $display("FAIL stall_data: got %h expected 00100", {m_tlast, m_tdata});
                end
                ready_mode = 0;
            end
        join
        wait_drain();
        // same packet with the clock enable toggling every cycle
        clken_mode = 2;
        exp_q.push_back(17'h0_0100);
        exp_q.push_back(17'h0_0300);
        exp_q.push_back(17'h1_0500);
        send_pkt(1);
        wait_drain();
        clken_mode = 0;
        step();
    endtask

    task automatic check_quiet(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_tvalid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL %s: got m_tvalid=1 expected no output", name);
        end
    endtask

    task automatic test_hold_and_reset();
        clken_mode = 0;
        ready_mode = 0;
        // open run without tlast is held indefinitely
        pkt = '{8'd20, 8'd21};
        send_pkt(0);
        repeat (50) step();
        n_cmp++;
        if (m_tvalid !== 1'b0 || dbg_state !== 2'd1) begin
            n_err++;
            $display("FAIL held_run: got valid=%b state=%0d expected 0 1", m_tvalid, dbg_state);
        end
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (m_tvalid !== 1'b0 || dbg_state !== 2'd0 || m_tdata !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got valid=%b state=%0d data=%h expected 0 0 0",
                     m_tvalid, dbg_state, m_tdata);
        end
        step();
        rst_n = 1'b1;
        check_quiet("quiet_after_run_reset");
        // reset while a closed run waits behind a stalled output slot
        ready_mode = 2;
        step();
        step();
        pkt = '{8'd30, 8'd40};
        send_pkt(1);
        step();
        n_cmp++;
        if (m_tvalid !== 1'b1 || dbg_state !== 2'd2) begin
            n_err++;
            $display("FAIL flush_wait: got valid=%b state=%0d expected 1 2", m_tvalid, dbg_state);
        end
        rst_n = 1'b0;
        ready_mode = 0;
        step();
        step();
        rst_n = 1'b1;
        check_quiet("quiet_after_flush_reset");
        pkt = '{8'd7};
        exp_q.push_back(17'h1_0700);
        send_pkt(1);
        wait_drain();
    endtask

    task automatic test_random();
        int len;
        int r;
        logic [ASIZE-1:0] a;
        clken_mode = 1;
        ready_mode = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 12);
            pkt.delete();
            a = ($urandom_range(0, 3) == 0) ? ASIZE'($urandom_range(250, 255))
                                             : ASIZE'($urandom_range(0, 255));
            pkt.push_back(a);
            for (int i = 1; i < len; i++) begin
                r = $urandom_range(0, 3);
                if (r < 2)       a = a + 8'd1;
                else if (r == 2) a = a + ASIZE'($urandom_range(2, 5));
                else             a = ASIZE'($urandom_range(0, 255));
                pkt.push_back(a);
            end
            model_pkt();
            send_pkt(1);
        end
        wait_drain();
        clken_mode = 0;
        ready_mode = 0;
        step();
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        test_reset();
        test_runs();
        test_latency();
        test_backpressure();
        test_hold_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
